// File: rtl/cond_logic_pkg.sv
// Shared definitions for the conditional-execution stage: condition codes,
// NZCV bit positions and the FlagW encoding agreed with the decoder.
package cond_logic_pkg;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;
   localparam logic [3:0] COND_NV = 4'b1111;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   localparam logic [1:0] FLAGW_NONE = 2'b00;
   localparam logic [1:0] FLAGW_CV   = 2'b01;
   localparam logic [1:0] FLAGW_NZ   = 2'b10;
   localparam logic [1:0] FLAGW_ALL  = 2'b11;

endpackage

// File: rtl/cond_logic_cond_check.sv
// Purely combinational evaluator of an ARM condition field against NZCV.
// NV (1111) is treated as "never" so reserved encodings cannot fire.
module cond_check
   import cond_logic_pkg::*;
(
   input  logic [3:0] i_cond,
   input  logic [3:0] i_flags,
   output logic       o_cond_ex
);

   logic w_n;
   logic w_z;
   logic w_c;
   logic w_v;
   logic w_ge;

   assign w_n  = i_flags[FLAG_N];
   assign w_z  = i_flags[FLAG_Z];
   assign w_c  = i_flags[FLAG_C];
   assign w_v  = i_flags[FLAG_V];
   assign w_ge = (w_n == w_v);

   always_comb begin
      o_cond_ex = 1'b0;
      case (i_cond)
         COND_EQ: o_cond_ex = w_z;
         COND_NE: o_cond_ex = ~w_z;
         COND_CS: o_cond_ex = w_c;
         COND_CC: o_cond_ex = ~w_c;
         COND_MI: o_cond_ex = w_n;
         COND_PL: o_cond_ex = ~w_n;
         COND_VS: o_cond_ex = w_v;
         COND_VC: o_cond_ex = ~w_v;
         COND_HI: o_cond_ex = w_c & ~w_z;
         COND_LS: o_cond_ex = ~w_c | w_z;
         COND_GE: o_cond_ex = w_ge;
         COND_LT: o_cond_ex = ~w_ge;
         COND_GT: o_cond_ex = ~w_z & w_ge;
         COND_LE: o_cond_ex = w_z | ~w_ge;
         COND_AL: o_cond_ex = 1'b1;
         default: o_cond_ex = 1'b0;
      endcase
   end

endmodule

// File: rtl/cond_logic.sv
// Conditional-execution stage: architectural NZCV register plus gating of the
// decoder's write intents by the evaluated condition and the stall input.
module cond_logic
   import cond_logic_pkg::*;
#(
   parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       Stall,
   input  logic [3:0] Cond,
   input  logic [3:0] ALUFlags,
   input  logic [1:0] FlagW,
   input  logic       PCS,
   input  logic       RegW,
   input  logic       MemW,
   input  logic       NoWrite,
   output logic       PCSrc,
   output logic       RegWrite,
   output logic       MemWrite,
   output logic       CondEx,
   output logic [3:0] Flags
);

   logic [1:0] r_flags_nz;
   logic [1:0] r_flags_cv;
   logic       w_cond_ex;
   logic       w_issue;

   // Condition is evaluated on the stored flags only; no ALUFlags forwarding.
   cond_check u_cond_check (
      .i_cond    (Cond),
      .i_flags   (Flags),
      .o_cond_ex (w_cond_ex)
   );

   assign w_issue  = w_cond_ex & ~Stall;

   assign CondEx   = w_cond_ex;
   assign PCSrc    = PCS & w_issue;
   assign RegWrite = RegW & ~NoWrite & w_issue;
   assign MemWrite = MemW & w_issue;
   assign Flags    = {r_flags_nz, r_flags_cv};

   // NZ and CV halves are written independently so logical ops keep C/V.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_flags_nz <= RESET_FLAGS[3:2];
         r_flags_cv <= RESET_FLAGS[1:0];
      end else if (w_issue) begin
         if (FlagW[1]) r_flags_nz <= ALUFlags[3:2];
         if (FlagW[0]) r_flags_cv <= ALUFlags[1:0];
      end
   end

endmodule

// File: tb/tb_cond_logic.sv
// Directed bench for cond_logic with a behavioural NZCV model checked every cycle.
module tb_cond_logic;

   logic       CLK;
   logic       RESET;
   logic       Stall;
   logic [3:0] Cond;
   logic [3:0] ALUFlags;
   logic [1:0] FlagW;
   logic       PCS;
   logic       RegW;
   logic       MemW;
   logic       NoWrite;
   logic       PCSrc;
   logic       RegWrite;
   logic       MemWrite;
   logic       CondEx;
   logic [3:0] Flags;

   int         n_checks = 0;
   int         n_pass   = 0;
   logic       chk_en   = 1'b0;
   logic [3:0] m_flags  = 4'b0000;

   cond_logic #(.RESET_FLAGS(4'b0000)) dut (
      .CLK      (CLK),
      .RESET    (RESET),
      .Stall    (Stall),
      .Cond     (Cond),
      .ALUFlags (ALUFlags),
      .FlagW    (FlagW),
      .PCS      (PCS),
      .RegW     (RegW),
      .MemW     (MemW),
      .NoWrite  (NoWrite),
      .PCSrc    (PCSrc),
      .RegWrite (RegWrite),
      .MemWrite (MemWrite),
      .CondEx   (CondEx),
      .Flags    (Flags)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // ARM encoding: pairs of conditions share a predicate, odd codes invert it.
   function automatic logic exp_cond(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cf, v, base;
      n = f[3]; z = f[2]; cf = f[1]; v = f[0];
      case (c[3:1])
         3'd0:    base = z;
         3'd1:    base = cf;
         3'd2:    base = n;
         3'd3:    base = v;
         3'd4:    base = cf && !z;
         3'd5:    base = (n == v);
         3'd6:    base = !z && (n == v);
         default: base = 1'b1;
      endcase
      return base ^ c[0];
   endfunction

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got %b expected %b", name, act, exp);
      else n_pass++;
   endtask

   always @(posedge CLK) begin
      if (RESET) m_flags = 4'b0000;
      else if (!Stall && exp_cond(Cond, m_flags)) begin
         if (FlagW[1]) m_flags[3:2] = ALUFlags[3:2];
         if (FlagW[0]) m_flags[1:0] = ALUFlags[1:0];
      end
   end

   always @(negedge CLK) begin
      if (chk_en) begin
         logic ce;
         ce = exp_cond(Cond, m_flags);
         check("model_CondEx",   {3'b0, CondEx},   {3'b0, ce});
         check("model_PCSrc",    {3'b0, PCSrc},    {3'b0, PCS & ce & !Stall});
         check("model_RegWrite", {3'b0, RegWrite}, {3'b0, RegW & !NoWrite & ce & !Stall});
         check("model_MemWrite", {3'b0, MemWrite}, {3'b0, MemW & ce & !Stall});
         check("model_Flags",    Flags,            m_flags);
      end
   end

   task automatic drive(input logic [3:0] c, input logic [1:0] fw, input logic [3:0] af,
                        input logic pcs, input logic rw, input logic mw, input logic nw,
                        input logic st, input logic rst);
      Cond = c; FlagW = fw; ALUFlags = af; PCS = pcs; RegW = rw; MemW = mw;
      NoWrite = nw; Stall = st; RESET = rst;
      #1;
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_flags(input logic [3:0] f);
      drive(4'b1110, 2'b11, f, 0, 0, 0, 0, 0, 0);
      tick();
   endtask

   initial begin
      logic [3:0] sweep [6];
      sweep[0] = 4'b0000; sweep[1] = 4'b1000; sweep[2] = 4'b1001;
      sweep[3] = 4'b0100; sweep[4] = 4'b0010; sweep[5] = 4'b0110;

      drive(4'b1110, 2'b00, 4'b0000, 0, 0, 0, 0, 0, 1);
      tick();
      tick();
      check("reset_flags", Flags, 4'b0000);
      chk_en = 1'b1;
      drive(4'b0000, 2'b00, 4'b0000, 0, 0, 0, 0, 0, 0);
      check("reset_EQ", {3'b0, CondEx}, 4'd0);
      tick();
      drive(4'b0001, 2'b00, 4'b0000, 0, 0, 0, 0, 0, 0);
      check("reset_NE", {3'b0, CondEx}, 4'd1);
      tick();

      // CMP then BEQ
      drive(4'b1110, 2'b11, 4'b0110, 0, 1, 0, 1, 0, 0);
      check("cmp_RegWrite", {3'b0, RegWrite}, 4'd0);
      tick();
      check("cmp_flags", Flags, 4'b0110);
      drive(4'b0000, 2'b00, 4'b0000, 1, 0, 0, 0, 0, 0);
      check("beq_PCSrc", {3'b0, PCSrc}, 4'd1);
      tick();

      // Partial flag writes
      set_flags(4'b0000);
      drive(4'b1110, 2'b10, 4'b1011, 0, 1, 0, 0, 0, 0);
      check("ands_RegWrite", {3'b0, RegWrite}, 4'd1);
      tick();
      check("ands_flags", Flags, 4'b1000);
      drive(4'b1110, 2'b11, 4'b0011, 0, 1, 0, 0, 0, 0);
      tick();
      check("adds_flags", Flags, 4'b0011);
      drive(4'b1110, 2'b01, 4'b1100, 0, 0, 0, 0, 0, 0);
      tick();
      check("cv_only_flags", Flags, 4'b0000);

      // Failed condition
      set_flags(4'b0100);
      drive(4'b0001, 2'b11, 4'b1111, 1, 1, 1, 0, 0, 0);
      check("fail_RegWrite", {3'b0, RegWrite}, 4'd0);
      check("fail_MemWrite", {3'b0, MemWrite}, 4'd0);
      check("fail_PCSrc", {3'b0, PCSrc}, 4'd0);
      tick();
      check("fail_flags", Flags, 4'b0100);

      // Condition sweep
      for (int i = 0; i < 6; i++) begin
         set_flags(sweep[i]);
         for (int c = 0; c < 16; c++) begin
            drive(c[3:0], 2'b00, 4'b0000, c[0], c[1], c[2], 0, 0, 0);
            check("sweep_CondEx", {3'b0, CondEx}, {3'b0, exp_cond(c[3:0], sweep[i])});
            if (c == 15) check("sweep_NV", {3'b0, CondEx}, 4'd0);
            if (i == 2 && c == 10) check("GE_1001", {3'b0, CondEx}, 4'd1);
            if (i == 1 && c == 11) check("LT_1000", {3'b0, CondEx}, 4'd1);
            if (i == 4 && c == 8)  check("HI_0010", {3'b0, CondEx}, 4'd1);
            if (i == 5 && c == 9)  check("LS_0110", {3'b0, CondEx}, 4'd1);
            if (i == 3 && c == 12) check("GT_0100", {3'b0, CondEx}, 4'd0);
            tick();
         end
      end

      // Stall, then reset priority over a flag write
      drive(4'b1110, 2'b11, 4'b1111, 1, 1, 1, 0, 1, 0);
      check("stall_MemWrite", {3'b0, MemWrite}, 4'd0);
      check("stall_CondEx", {3'b0, CondEx}, 4'd1);
      tick();
      check("stall_flags", Flags, 4'b0110);
      drive(4'b1110, 2'b11, 4'b1111, 0, 0, 1, 0, 0, 1);
      check("rst_cycle_MemWrite", {3'b0, MemWrite}, 4'd1);
      tick();
      check("rst_priority_flags", Flags, 4'b0000);
      drive(4'b1110, 2'b00, 4'b0000, 0, 0, 0, 0, 0, 0);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
